// File: rtl/xsip_ctrl_frame_tx.sv
// Host-side XR-BUS control-frame transmitter: queues commands, packs them into frames,
// waits for ack/timeout and enforces an inter-frame gap. Optional CRC: XSIP_CTRL_FRAME_CRC_EN.
module xsip_ctrl_frame_tx #(
    parameter int unsigned FRAME_W        = 4096,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [7:0]         cmd_code,
    input  logic [7:0]         cmd_type,
    input  logic [3:0]         cmd_domain,
    input  logic [3:0]         cmd_dbg_hi,
    input  logic [31:0]        cmd_param,
    input  logic [31:0]        cmd_value,
    input  logic [31:0]        cmd_data,
    output logic [FRAME_W-1:0] frame_out,
    output logic               frame_valid_out,
    input  logic               resp_ack,
    input  logic [7:0]         resp_status,
    output logic               done_valid,
    output logic [7:0]         done_status,
    output logic               timeout_err,
    output logic               busy,
    output logic [15:0]        frames_sent
);

    localparam int unsigned PAY_W   = 160;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned QCNT_W  = PTR_W + 1;
    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    localparam logic [2:0] S_IDLE = 3'd0;
`ifdef XSIP_CTRL_FRAME_CRC_EN
    localparam logic [2:0] S_CRC  = 3'd1;
    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
`endif
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] value;
        logic [31:0] param;
        logic [3:0]  dbg_hi;
        logic [3:0]  domain;
        logic [7:0]  ctype;
        logic [7:0]  code;
    } cmd_t;

    cmd_t               r_mem [FIFO_DEPTH];
    cmd_t               w_head;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [QCNT_W-1:0]  r_count;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_ack_hit;
    logic               w_tmo_hit;

    logic [PAY_W-1:0]   r_frame;
    logic               r_frame_valid;
    logic               r_done_valid;
    logic [7:0]         r_done_status;
    logic               r_timeout_err;
    logic [15:0]        r_frames_sent;
    logic [7:0]         r_seq;

`ifdef XSIP_CTRL_FRAME_CRC_EN
    // MSB-first CRC-32 over 16 bytes, byte [7:0] first
    function automatic logic [31:0] crc32_128(input logic [127:0] d);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int b = 0; b < 16; b++) begin
            for (int i = 7; i >= 0; i--) begin
                if (c[31] ^ d[8*b + i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
                else                    c = {c[30:0], 1'b0};
            end
        end
        return ~c;
    endfunction
`endif

    assign w_full    = (r_count == QCNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = cmd_valid && !w_full;
    assign w_head    = r_mem[r_rd_ptr];
    assign cmd_ready = !w_full;
    assign busy      = (r_state != S_IDLE) || !w_empty;

    assign frame_out       = FRAME_W'(r_frame);
    assign frame_valid_out = r_frame_valid;
    assign done_valid      = r_done_valid;
    assign done_status     = r_done_status;
    assign timeout_err     = r_timeout_err;
    assign frames_sent     = r_frames_sent;

    // Command storage; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= cmd_t'({cmd_data, cmd_value, cmd_param,
                                               cmd_dbg_hi, cmd_domain, cmd_type, cmd_code});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + QCNT_W'(1);
                2'b01:   r_count <= r_count - QCNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Next state; r_cnt is shared by the ack timer and the gap counter
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_pop        = 1'b0;
        w_ack_hit    = 1'b0;
        w_tmo_hit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
`ifdef XSIP_CTRL_FRAME_CRC_EN
                    w_next_state = S_CRC;
`else
                    w_next_state = S_SEND;
`endif
                end
            end
`ifdef XSIP_CTRL_FRAME_CRC_EN
            S_CRC: w_next_state = S_SEND;
`endif
            S_SEND: begin
                w_next_state = S_WAIT;
                w_cnt_next   = '0;
            end
            S_WAIT: begin
                if (resp_ack) begin
                    w_ack_hit    = 1'b1;
                    w_next_state = S_GAP;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_tmo_hit    = 1'b1;
                    w_next_state = S_GAP;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    w_next_state = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_frame       <= '0;
            r_frame_valid <= 1'b0;
            r_done_valid  <= 1'b0;
            r_done_status <= 8'h00;
            r_timeout_err <= 1'b0;
            r_frames_sent <= 16'h0000;
            r_seq         <= 8'h00;
        end else begin
            r_state       <= w_next_state;
            r_cnt         <= w_cnt_next;
            r_frame_valid <= (w_next_state == S_SEND);
            r_done_valid  <= w_ack_hit || w_tmo_hit;
            r_timeout_err <= w_tmo_hit;
            if (w_ack_hit)      r_done_status <= resp_status;
            else if (w_tmo_hit) r_done_status <= 8'hEE;
            if (w_pop) begin
                r_frame <= {32'h0, w_head.data, w_head.value, w_head.param,
                            r_seq, w_head.dbg_hi, w_head.domain, w_head.ctype, w_head.code};
            end
`ifdef XSIP_CTRL_FRAME_CRC_EN
            if (r_state == S_CRC) r_frame[159:128] <= crc32_128(r_frame[127:0]);
`endif
            // seq stamps the frame currently on the bus, so it advances on leaving SEND
            if (r_state == S_SEND) begin
                r_seq <= r_seq + 8'd1;
                if (r_frames_sent != 16'hFFFF) r_frames_sent <= r_frames_sent + 16'd1;
            end
        end
    end

endmodule

// File: doc/xsip_ctrl_frame_tx.md
Name: xsip_ctrl_frame_tx

Overview:
Host-side XR-BUS control-frame transmitter. It produces the control frames that the XSIP top consumes on its XR-BUS frame input. It queues control/power/debug commands, packs them into 4096-bit frames, and issues a one-cycle frame valid for each frame. After each frame it waits for an acknowledge or a timeout, then enforces a minimum inter-frame gap before the next frame.

Parameters:
FRAME_W, 4096, XR-BUS frame width in bits
FIFO_DEPTH, 4, command queue entries (power of two, ≥2)
GAP_CYCLES, 4, idle cycles between the end of one command and the next frame (≥1)
TIMEOUT_CYCLES, 1024, WAIT_ACK cycles before a timeout is declared (≥2)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  queue can accept; equals !full
cmd_code  in  8  EC control code
cmd_type  in  8  power control type
cmd_domain  in  4  target domain
cmd_dbg_hi  in  4  debug command upper nibble
cmd_param  in  32  EC control parameter
cmd_value  in  32  power control value
cmd_data  in  32  debug data
frame_out  out  FRAME_W  packed frame
frame_valid_out  out  1  one-cycle frame strobe
resp_ack  in  1  acknowledge from the far end
resp_status  in  8  status qualifying resp_ack
done_valid  out  1  one-cycle command completion pulse
done_status  out  8  resp_status, or 8'hEE on timeout
timeout_err  out  1  one-cycle pulse on timeout
busy  out  1  FSM not IDLE, or queue not empty
frames_sent  out  16  saturating frame counter

Behaviour:
- Frame layout:
  - [7:0] code, [15:8] type, [19:16] domain, [23:20] dbg_hi
  - [31:24] seq, an 8-bit counter that increments after each SEND and wraps 255→0
  - [63:32] param, [95:64] value, [127:96] data
  - All remaining bits are 0.
- Reset values: frame_out=0, frame_valid_out=0, done_valid=0, done_status=0, timeout_err=0, frames_sent=0, seq=0, queue empty, FSM=IDLE, so cmd_ready=1 and busy=0.
- Queue:
  - Push on cmd_valid&&cmd_ready.
  - When full, cmd_ready=0 even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full leaves the count unchanged.
- FSM states and transitions:
  - IDLE: if queue not empty, pop the head, register frame_out, go to SEND.
  - SEND: frame_valid_out=1 for exactly this cycle; frames_sent++ (holds at 65535); seq++; go to WAIT_ACK with timer=0.
  - WAIT_ACK:
    - On resp_ack: done_valid=1 and done_status=resp_status on the next cycle; go to GAP.
    - Otherwise timer++. When the timer reaches TIMEOUT_CYCLES-1 with no ack: done_valid=1, done_status=8'hEE, timeout_err=1; go to GAP.
    - If ack arrives in the same cycle as expiry, ack wins and there is no timeout.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- resp_ack is sampled only in WAIT_ACK; an ack during IDLE, SEND or GAP is ignored.
- frame_out holds its value until the next IDLE load.
- Latency from idle with an empty queue: if a command is accepted at edge N, frame_valid_out is high in cycle N+2.
- Back-to-back spacing: the minimum distance from one frame_valid_out to the next is 1 (SEND) + ack latency + GAP_CYCLES + 1 (IDLE).
- Reset asserted mid-operation: on the next edge all state returns to reset values and queued commands are discarded; no done_valid is produced for in-flight commands.

Optional Feature:
Macro XSIP_CTRL_FRAME_CRC_EN.
- Defined:
  - Adds a CRC state between IDLE and SEND.
  - The CRC state computes CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, no reflection, final XOR 0xFFFFFFFF) over frame bits [127:0], with the byte at [7:0] processed first.
  - The result goes into [159:128].
  - Frame latency from acceptance becomes N+3.
- Undefined: no CRC state, bits [159:128]=0, latency N+2.

Test Plan:
- Reset then a single command: code=8'h12, type=8'h03, domain=4'h5, dbg_hi=4'hA, param=32'hDEADBEEF, value=32'h000C3500, data=32'h1. Expect frame_valid_out high at N+2; frame[31:0]=32'h00A50312; [63:32]=DEADBEEF; [95:64]=000C3500; [127:96]=1; all upper bits 0; frames_sent=1.
- Ack after 3 cycles with resp_status=8'h5A → done_valid pulse with done_status=8'h5A. The next queued frame's strobe is exactly 1+3+4+1 cycles later (GAP_CYCLES=4), and its seq=1.
- No ack with TIMEOUT_CYCLES=16 → timeout_err and done_valid pulse 16 cycles after entering WAIT_ACK, done_status=8'hEE. Ack on the expiry cycle instead → status=resp_status and no timeout_err.
- Push 6 commands with cmd_valid held high, FIFO_DEPTH=4 → cmd_ready drops after 4 pushes (one pop may free a slot). All accepted commands are sent in order; none is lost or duplicated.
- 257 commands → seq field wraps from 8'hFF to 8'h00; frames_sent=257.
- rst pulsed during WAIT_ACK with 2 commands queued → next cycle busy=0, cmd_ready=1, frames_sent=0, no further frames. With XSIP_CTRL_FRAME_CRC_EN: an all-zero payload frame has [159:128] equal to the reference CRC-32 of 16 zero bytes.
